// File: rtl/ex_issue_stage_pkg.sv
// ex_issue_stage shared types: ALU control codes, ALUOp and funct3.
// Build option: FORWARDING_EN enables operand forwarding and stall snoop.
package ex_issue_stage_pkg;

  localparam int XLEN    = 32;
  localparam int REGADDR = 5;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_MEM = 2'b00,
    ALUOP_BR  = 2'b01,
    ALUOP_R   = 2'b10,
    ALUOP_I   = 2'b11
  } alu_op_e;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

endpackage

// File: rtl/ex_issue_stage_if.sv
// ex_issue_stage bus: ID-side capture, forwarding taps, EX-side output.
// Build option: FORWARDING_EN (taps are ignored when undefined).
interface ex_issue_stage_if #(
  parameter int XLEN    = 32,
  parameter int REGADDR = 5
);
  logic               InValid;
  logic               InReady;
  logic [XLEN-1:0]    Rs1Data;
  logic [XLEN-1:0]    Rs2Data;
  logic [XLEN-1:0]    Imm;
  logic [REGADDR-1:0] Rs1;
  logic [REGADDR-1:0] Rs2;
  logic [REGADDR-1:0] Rd;
  logic               ALUSrc;
  logic [1:0]         ALUOp;
  logic [2:0]         Funct3;
  logic               Funct7b5;
  logic               Flush;
  logic               ExMemRegWrite;
  logic [REGADDR-1:0] ExMemRd;
  logic [XLEN-1:0]    ExMemData;
  logic               MemWbRegWrite;
  logic [REGADDR-1:0] MemWbRd;
  logic [XLEN-1:0]    MemWbData;
  logic               OutValid;
  logic               OutReady;
  logic [XLEN-1:0]    A;
  logic [XLEN-1:0]    B;
  logic [3:0]         ALUCtrl;
  logic [REGADDR-1:0] OutRd;
  logic               Illegal;

  modport slave (
    input  InValid, Rs1Data, Rs2Data, Imm,
    input  Rs1, Rs2, Rd, ALUSrc, ALUOp,
    input  Funct3, Funct7b5, Flush,
    input  ExMemRegWrite, ExMemRd, ExMemData,
    input  MemWbRegWrite, MemWbRd, MemWbData,
    input  OutReady,
    output InReady, OutValid, A, B,
    output ALUCtrl, OutRd, Illegal
  );

  modport master (
    output InValid, Rs1Data, Rs2Data, Imm,
    output Rs1, Rs2, Rd, ALUSrc, ALUOp,
    output Funct3, Funct7b5, Flush,
    output ExMemRegWrite, ExMemRd, ExMemData,
    output MemWbRegWrite, MemWbRd, MemWbData,
    output OutReady,
    input  InReady, OutValid, A, B,
    input  ALUCtrl, OutRd, Illegal
  );
endinterface

// File: rtl/ex_issue_stage_alu_ctrl_dec.sv
// ALUOp/funct3/funct7b5 -> 4-bit ALU control decoder.
// Unsupported funct3 under R/I ops decode as ADD with illegal flagged.
module alu_ctrl_dec
  import ex_issue_stage_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [3:0] alu_ctrl_o,
  output logic       illegal_o
);

  // decode ALU control from op class, then funct fields
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    illegal_o  = 1'b0;
    unique case (1'b1)
      (alu_op_i == ALUOP_MEM): alu_ctrl_o = ALU_ADD;
      (alu_op_i == ALUOP_BR):  alu_ctrl_o = ALU_SUB;
      alu_op_i[1]: begin
        unique case (funct3_i)
          F3_ADD: begin
            if ((alu_op_i == ALUOP_R) && funct7b5_i)
              alu_ctrl_o = ALU_SUB;
            else
              alu_ctrl_o = ALU_ADD;
          end
          F3_AND: alu_ctrl_o = ALU_AND;
          F3_OR:  alu_ctrl_o = ALU_OR;
          F3_SLT: alu_ctrl_o = ALU_SLT;
          default: begin
            alu_ctrl_o = ALU_ADD;
            illegal_o  = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX register feeding the ALU: decode, operand select, handshake.
// Build option: FORWARDING_EN adds EX/MEM+MEM/WB forwarding and snoop.
module ex_issue_stage
  import ex_issue_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REGADDR = 5
)(
  input logic              clk,
  input logic              reset,
  ex_issue_stage_if.slave  io
);

  logic               valid_q, valid_d;
  logic [XLEN-1:0]    a_q, a_d;
  logic [XLEN-1:0]    rs2v_q, rs2v_d;
  logic [XLEN-1:0]    imm_q, imm_d;
  logic               src_q, src_d;
  logic [REGADDR-1:0] rs1_q, rs1_d;
  logic [REGADDR-1:0] rs2_q, rs2_d;
  logic [REGADDR-1:0] rd_q, rd_d;
  logic [3:0]         ctrl_q, ctrl_d;
  logic               ill_q, ill_d;

  logic [3:0]         dec_ctrl;
  logic               dec_ill;
  logic [XLEN-1:0]    rs1_val;
  logic [XLEN-1:0]    rs2_val;
  logic               take;
  logic               stall;

  function automatic logic hit(
    input logic               we,
    input logic [REGADDR-1:0] rd,
    input logic [REGADDR-1:0] rs
  );
    return we && (rd == rs) && (rs != '0);
  endfunction

  alu_ctrl_dec u_dec (
    .alu_op_i   (io.ALUOp),
    .funct3_i   (io.Funct3),
    .funct7b5_i (io.Funct7b5),
    .alu_ctrl_o (dec_ctrl),
    .illegal_o  (dec_ill)
  );

  assign io.InReady  = !valid_q || io.OutReady;
  assign take        = io.InValid && io.InReady;
  assign stall       = valid_q && !io.OutReady;

  assign io.OutValid = valid_q;
  assign io.A        = a_q;
  assign io.B        = src_q ? imm_q : rs2v_q;
  assign io.ALUCtrl  = ctrl_q;
  assign io.OutRd    = rd_q;
  assign io.Illegal  = ill_q;

`ifdef FORWARDING_EN
  // source operands: EX/MEM beats MEM/WB beats regfile, x0 reads 0
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (io.Rs1 != '0) begin
      if (hit(io.ExMemRegWrite, io.ExMemRd, io.Rs1))
        rs1_val = io.ExMemData;
      else if (hit(io.MemWbRegWrite, io.MemWbRd, io.Rs1))
        rs1_val = io.MemWbData;
      else
        rs1_val = io.Rs1Data;
    end
    if (io.Rs2 != '0) begin
      if (hit(io.ExMemRegWrite, io.ExMemRd, io.Rs2))
        rs2_val = io.ExMemData;
      else if (hit(io.MemWbRegWrite, io.MemWbRd, io.Rs2))
        rs2_val = io.MemWbData;
      else
        rs2_val = io.Rs2Data;
    end
  end
`else
  // source operands straight from the regfile, x0 reads 0
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (io.Rs1 != '0) rs1_val = io.Rs1Data;
    if (io.Rs2 != '0) rs2_val = io.Rs2Data;
  end

  logic unused_fwd;
  assign unused_fwd = ^{io.ExMemRegWrite, io.ExMemRd,
                        io.ExMemData, io.MemWbRegWrite,
                        io.MemWbRd, io.MemWbData,
                        rs1_q, rs2_q};
`endif

  // next state: capture, snoop while stalled, flush kills
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    rs2v_d  = rs2v_q;
    imm_d   = imm_q;
    src_d   = src_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    ill_d   = ill_q;

    if (take && !io.Flush) begin
      a_d    = rs1_val;
      rs2v_d = rs2_val;
      imm_d  = io.Imm;
      src_d  = io.ALUSrc;
      rs1_d  = io.Rs1;
      rs2_d  = io.Rs2;
      rd_d   = io.Rd;
      ctrl_d = dec_ctrl;
      ill_d  = dec_ill;
    end
`ifdef FORWARDING_EN
    else if (stall) begin
      if (hit(io.MemWbRegWrite, io.MemWbRd, rs1_q))
        a_d = io.MemWbData;
      if (hit(io.MemWbRegWrite, io.MemWbRd, rs2_q))
        rs2v_d = io.MemWbData;
    end
`endif

    if (io.Flush)
      valid_d = 1'b0;
    else if (take)
      valid_d = 1'b1;
    else if (io.OutReady)
      valid_d = 1'b0;
  end

  // pipeline register with async reset to an idle ADD
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      rs2v_q  <= '0;
      imm_q   <= '0;
      src_q   <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      ctrl_q  <= ALU_ADD;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      rs2v_q  <= rs2v_d;
      imm_q   <= imm_d;
      src_q   <= src_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
      ill_q   <= ill_d;
    end
  end

endmodule

// File: tb/tb_ex_issue_stage.sv
// Randomized scoreboard bench for ex_issue_stage.
// Reference model tracks FORWARDING_EN the same way as the design.
module tb_ex_issue_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ex_issue_stage_if #(.XLEN(32), .REGADDR(5)) bus();

  ex_issue_stage #(.XLEN(32), .REGADDR(5)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] rs2v;
    logic [31:0] imm;
    bit          src;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  ctrl;
    bit          ill;
  } exp_t;

  exp_t q[$];
  bit   m_valid = 0;
  int   n_total = 0;
  int   n_pass  = 0;
  int   xfers   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h @%0t",
                  nm, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_src(input logic [4:0] rs,
                                          input logic [31:0] rf);
    if (rs == 5'd0) return 32'd0;
`ifdef FORWARDING_EN
    if (bus.ExMemRegWrite && bus.ExMemRd == rs) return bus.ExMemData;
    if (bus.MemWbRegWrite && bus.MemWbRd == rs) return bus.MemWbData;
`endif
    return rf;
  endfunction

  task automatic ref_dec(input logic [1:0] op, input logic [2:0] f3,
                         input logic f7, output logic [3:0] c,
                         output bit ill);
    ill = 0;
    c   = 4'b0010;
    if (op == 2'b01) c = 4'b0110;
    else if (op[1]) begin
      case (f3)
        3'b000: if (op == 2'b10 && f7) c = 4'b0110;
        3'b111: c = 4'b0000;
        3'b110: c = 4'b0001;
        3'b010: c = 4'b0111;
        default: ill = 1;
      endcase
    end
  endtask

  // reference model: advance on each clock using pre-edge inputs
  always @(posedge clk) begin
    bit   rdy;
    exp_t e;
    if (reset) begin
      q.delete();
      m_valid = 0;
    end else if (bus.Flush) begin
      q.delete();
      m_valid = 0;
    end else begin
      rdy = !m_valid || bus.OutReady;
`ifdef FORWARDING_EN
      if (m_valid && !bus.OutReady && q.size() != 0) begin
        e = q[0];
        if (bus.MemWbRegWrite && e.rs1 != 0 && bus.MemWbRd == e.rs1)
          e.a = bus.MemWbData;
        if (bus.MemWbRegWrite && e.rs2 != 0 && bus.MemWbRd == e.rs2)
          e.rs2v = bus.MemWbData;
        q[0] = e;
      end
`endif
      if (m_valid && bus.OutReady) m_valid = 0;
      if (bus.InValid && rdy) begin
        e.a    = ref_src(bus.Rs1, bus.Rs1Data);
        e.rs2v = ref_src(bus.Rs2, bus.Rs2Data);
        e.imm  = bus.Imm;
        e.src  = bus.ALUSrc;
        e.rs1  = bus.Rs1;
        e.rs2  = bus.Rs2;
        e.rd   = bus.Rd;
        ref_dec(bus.ALUOp, bus.Funct3, bus.Funct7b5, e.ctrl, e.ill);
        q.push_back(e);
        m_valid = 1;
      end
    end
  end

  // monitor: compare presented output with queue head, pop on consume
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("InReady", 32'(bus.InReady), 32'(!m_valid || bus.OutReady));
      chk("OutValid", 32'(bus.OutValid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        e = q[0];
        chk("A", bus.A, e.a);
        chk("B", bus.B, e.src ? e.imm : e.rs2v);
        chk("ALUCtrl", 32'(bus.ALUCtrl), 32'(e.ctrl));
        chk("OutRd", 32'(bus.OutRd), 32'(e.rd));
        chk("Illegal", 32'(bus.Illegal), 32'(e.ill));
        if (bus.OutReady) begin
          void'(q.pop_front());
          xfers++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.InValid = 0; bus.Rs1Data = 0; bus.Rs2Data = 0; bus.Imm = 0;
    bus.Rs1 = 0; bus.Rs2 = 0; bus.Rd = 0; bus.ALUSrc = 0;
    bus.ALUOp = 0; bus.Funct3 = 0; bus.Funct7b5 = 0; bus.Flush = 0;
    bus.ExMemRegWrite = 0; bus.ExMemRd = 0; bus.ExMemData = 0;
    bus.MemWbRegWrite = 0; bus.MemWbRd = 0; bus.MemWbData = 0;
  endtask

  task automatic instr(input logic [1:0] op, input logic [2:0] f3,
                       input logic f7, input logic src,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] imm);
    bus.InValid = 1; bus.ALUOp = op; bus.Funct3 = f3;
    bus.Funct7b5 = f7; bus.ALUSrc = src; bus.Rs1 = r1; bus.Rs2 = r2;
    bus.Rd = rd; bus.Rs1Data = d1; bus.Rs2Data = d2; bus.Imm = imm;
  endtask

  initial begin
    int x0;
    idle();
    bus.OutReady = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_OutValid", 32'(bus.OutValid), 32'd0);
    chk("rst_A", bus.A, 32'd0);
    chk("rst_B", bus.B, 32'd0);
    chk("rst_ALUCtrl", 32'(bus.ALUCtrl), 32'h2);
    chk("rst_OutRd", 32'(bus.OutRd), 32'd0);
    chk("rst_Illegal", 32'(bus.Illegal), 32'd0);
    step();
    reset = 0;
    step();

    bus.OutReady = 1;
    instr(2'b10, 3'b000, 1, 0, 5'd1, 5'd2, 5'd4, 32'd7, 32'd9, 32'd0);
    step();
    instr(2'b11, 3'b010, 0, 1, 5'd1, 5'd2, 5'd6, 32'd1, 32'd2,
          32'hFFFF_FFFF);
    step();
    instr(2'b11, 3'b001, 0, 1, 5'd1, 5'd2, 5'd7, 32'd1, 32'd2, 32'd3);
    step();
    bus.ExMemRegWrite = 1; bus.ExMemRd = 5; bus.ExMemData = 32'h11;
    bus.MemWbRegWrite = 1; bus.MemWbRd = 5; bus.MemWbData = 32'h22;
    instr(2'b00, 3'b000, 0, 0, 5'd5, 5'd5, 5'd8, 32'h33, 32'h44, 32'd0);
    step();
    instr(2'b00, 3'b000, 0, 0, 5'd0, 5'd0, 5'd8, 32'h33, 32'h44, 32'd0);
    step();
    idle();
    step();

    bus.OutReady = 0;
    instr(2'b10, 3'b111, 0, 0, 5'd1, 5'd3, 5'd9, 32'h5, 32'h6, 32'd0);
    step();
    bus.InValid = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        bus.MemWbRegWrite = 1; bus.MemWbRd = 3;
        bus.MemWbData = 32'hABCD;
      end else begin
        bus.MemWbRegWrite = 0;
      end
      step();
      chk("stall_InReady", 32'(bus.InReady), 32'd0);
      chk("stall_OutRd", 32'(bus.OutRd), 32'd9);
    end
    bus.MemWbRegWrite = 0;
    bus.OutReady = 1;
    step();

    instr(2'b10, 3'b110, 0, 0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'd0);
    bus.Flush = 1;
    step();
    idle();
    chk("flush_OutValid", 32'(bus.OutValid), 32'd0);
    bus.OutReady = 0;
    instr(2'b01, 3'b000, 0, 0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'd0);
    step();
    idle();
    bus.Flush = 1;
    step();
    bus.Flush = 0;
    chk("flush_held", 32'(bus.OutValid), 32'd0);
    bus.OutReady = 1;
    step();

    x0 = xfers;
    for (int i = 0; i < 4; i++) begin
      instr(2'(i), 3'(i), 0, 0, 5'(i + 1), 5'(i + 2), 5'(i + 10),
            32'(i * 3), 32'(i * 5), 32'd0);
      step();
    end
    idle();
    step();
    chk("b2b_xfers", 32'(xfers - x0), 32'd4);

    for (int i = 0; i < 400; i++) begin
      bus.InValid = $urandom_range(0, 3) != 0;
      bus.Rs1 = 5'($urandom_range(0, 3));
      bus.Rs2 = 5'($urandom_range(0, 3));
      bus.Rd = 5'($urandom);
      bus.Rs1Data = $urandom; bus.Rs2Data = $urandom;
      bus.Imm = $urandom; bus.ALUSrc = 1'($urandom);
      bus.ALUOp = 2'($urandom); bus.Funct3 = 3'($urandom);
      bus.Funct7b5 = 1'($urandom);
      bus.ExMemRegWrite = 1'($urandom);
      bus.ExMemRd = 5'($urandom_range(0, 3));
      bus.ExMemData = $urandom;
      bus.MemWbRegWrite = 1'($urandom);
      bus.MemWbRd = 5'($urandom_range(0, 3));
      bus.MemWbData = $urandom;
      bus.OutReady = $urandom_range(0, 9) < 6;
      bus.Flush = !m_valid && ($urandom_range(0, 19) == 0);
      step();
    end
    idle();

    bus.OutReady = 0;
    instr(2'b10, 3'b111, 0, 0, 5'd1, 5'd2, 5'd12, 32'h1, 32'h2, 32'd0);
    step();
    idle();
    chk("pre_rst_OutValid", 32'(bus.OutValid), 32'd1);
    #1 reset = 1;
    #1;
    chk("async_rst_OutValid", 32'(bus.OutValid), 32'd0);
    chk("async_rst_ALUCtrl", 32'(bus.ALUCtrl), 32'h2);
    chk("async_rst_OutRd", 32'(bus.OutRd), 32'd0);
    step();
    reset = 0;
    bus.OutReady = 1;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
